// File: rtl/lmi_dcache_ctrl.sv
// lmi_dcache_ctrl: data cache sequencer - tag init walk, refill, uncached read, write-through
// Ports:
//   CLK, RESET            clock, asynchronous active-high reset
//   REQ/WR/KSEG1/ADDR/HIT pipeline request and tag-compare result
//   STALL                 pipeline stall
//   BUS_REQ/BUS_RD/BUS_ADDR/BUS_ACK  LMI bus handshake, one ACK per word beat
//   TAG_WE/TAG_VAL/TAG_IDX           tag RAM write port
//   DATA_WE/DATA_WIDX                data RAM refill write port
//   UNC_VALID/FILL_DONE/INIT_BUSY    completion and status pulses
module lmi_dcache_ctrl #(
    parameter int LINE_WORDS = 4,
    parameter int WIDX_BITS  = 2,
    parameter int INDEX_BITS = 9
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  REQ,
    input  logic                  WR,
    input  logic                  KSEG1,
    input  logic [31:0]           ADDR,
    input  logic                  HIT,
    output logic                  STALL,
    output logic                  BUS_REQ,
    output logic                  BUS_RD,
    output logic [31:0]           BUS_ADDR,
    input  logic                  BUS_ACK,
    output logic                  TAG_WE,
    output logic                  TAG_VAL,
    output logic [INDEX_BITS-1:0] TAG_IDX,
    output logic                  DATA_WE,
    output logic [WIDX_BITS-1:0]  DATA_WIDX,
    output logic                  UNC_VALID,
    output logic                  FILL_DONE,
    output logic                  INIT_BUSY
);
    typedef enum logic [2:0] {S_INIT, S_IDLE, S_REFILL, S_TAGWR, S_UNCRD, S_WRITE} state_t;
    state_t state, state_nx;
    logic [INDEX_BITS-1:0] init_cnt;
    logic [WIDX_BITS-1:0]  beat;
    logic [31:0]           addr_r;
    logic                  idle_go;
    // any IDLE request that is not a cached load hit leaves IDLE
    assign idle_go   = (state == S_IDLE) && REQ && (WR || KSEG1 || !HIT);
    assign DATA_WIDX = beat;
    always_ff @(posedge CLK or posedge RESET)
        if (RESET) state <= S_INIT;
        else state <= state_nx;
    always_ff @(posedge CLK or posedge RESET)
        if (RESET) begin
            init_cnt <= '0;
            beat     <= '0;
            addr_r   <= '0;
        end else begin
            if (state == S_INIT) init_cnt <= init_cnt + INDEX_BITS'(1);
            if (idle_go) addr_r <= ADDR;
            if (state == S_IDLE) beat <= '0;
            else if (state == S_REFILL && BUS_ACK) beat <= beat + WIDX_BITS'(1);
        end
    always_comb begin
        state_nx  = state;
        STALL     = 1'b0;
        BUS_REQ   = 1'b0;
        BUS_RD    = 1'b0;
        BUS_ADDR  = '0;
        TAG_WE    = 1'b0;
        TAG_VAL   = 1'b0;
        TAG_IDX   = init_cnt;
        DATA_WE   = 1'b0;
        UNC_VALID = 1'b0;
        FILL_DONE = 1'b0;
        INIT_BUSY = 1'b0;
        case (state)
            S_INIT: begin
                STALL     = 1'b1;
                INIT_BUSY = 1'b1;
                TAG_WE    = 1'b1;
                state_nx  = &init_cnt ? S_IDLE : S_INIT;
            end
            S_IDLE: begin
                STALL    = idle_go;
                state_nx = !REQ ? S_IDLE : WR ? S_WRITE : KSEG1 ? S_UNCRD : HIT ? S_IDLE : S_REFILL;
            end
            S_REFILL: begin
                STALL    = 1'b1;
                BUS_REQ  = 1'b1;
                BUS_RD   = 1'b1;
                BUS_ADDR = {addr_r[31:WIDX_BITS+2], beat, 2'b00};
                DATA_WE  = BUS_ACK;
                state_nx = (BUS_ACK && &beat) ? S_TAGWR : S_REFILL;
            end
            S_TAGWR: begin
                STALL     = 1'b1;
                TAG_WE    = 1'b1;
                TAG_VAL   = 1'b1;
                TAG_IDX   = addr_r[INDEX_BITS+WIDX_BITS+1:WIDX_BITS+2];
                FILL_DONE = 1'b1;
                state_nx  = S_IDLE;
            end
            S_UNCRD: begin
                STALL     = !BUS_ACK;
                BUS_REQ   = 1'b1;
                BUS_RD    = 1'b1;
                BUS_ADDR  = {addr_r[31:2], 2'b00};
                UNC_VALID = BUS_ACK;
                state_nx  = BUS_ACK ? S_IDLE : S_UNCRD;
            end
            S_WRITE: begin
                STALL    = !BUS_ACK;
                BUS_REQ  = 1'b1;
                BUS_ADDR = {addr_r[31:2], 2'b00};
                state_nx = BUS_ACK ? S_IDLE : S_WRITE;
            end
            default: state_nx = S_INIT;
        endcase
    end
endmodule

// File: tb/tb_lmi_dcache_ctrl.sv
// tb_lmi_dcache_ctrl: table-driven scoreboard bench for lmi_dcache_ctrl
module tb_lmi_dcache_ctrl;
    typedef struct packed {
        logic        req, wr, kseg1;
        logic [31:0] addr;
        logic        hit, ack;
    } in_t;
    typedef struct packed {
        logic        stall, bus_req, bus_rd;
        logic [31:0] bus_addr;
        logic        tag_we, tag_val;
        logic [8:0]  tag_idx;
        logic        data_we;
        logic [1:0]  data_widx;
        logic        unc_valid, fill_done, init_busy;
    } out_t;
    typedef struct packed {
        in_t  i;
        out_t e;
    } vec_t;
    logic        CLK, RESET, REQ, WR, KSEG1, HIT, BUS_ACK;
    logic [31:0] ADDR, BUS_ADDR;
    logic        STALL, BUS_REQ, BUS_RD, TAG_WE, TAG_VAL, DATA_WE, UNC_VALID, FILL_DONE, INIT_BUSY;
    logic [8:0]  TAG_IDX;
    logic [1:0]  DATA_WIDX;
    int checks = 0;
    int failures = 0;
    out_t sb[$];
    vec_t tbl[$];
    lmi_dcache_ctrl dut (
        .CLK(CLK), .RESET(RESET), .REQ(REQ), .WR(WR), .KSEG1(KSEG1), .ADDR(ADDR), .HIT(HIT),
        .STALL(STALL), .BUS_REQ(BUS_REQ), .BUS_RD(BUS_RD), .BUS_ADDR(BUS_ADDR), .BUS_ACK(BUS_ACK),
        .TAG_WE(TAG_WE), .TAG_VAL(TAG_VAL), .TAG_IDX(TAG_IDX), .DATA_WE(DATA_WE),
        .DATA_WIDX(DATA_WIDX), .UNC_VALID(UNC_VALID), .FILL_DONE(FILL_DONE), .INIT_BUSY(INIT_BUSY)
    );
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end
    function automatic in_t ii(logic req, logic wr, logic k, logic [31:0] a, logic hit, logic ack);
        return '{req: req, wr: wr, kseg1: k, addr: a, hit: hit, ack: ack};
    endfunction
    function automatic out_t o(logic st, logic br, logic rd, logic [31:0] ba, logic tw, logic tv,
                               logic [8:0] ti, logic dw, logic [1:0] wi, logic uv, logic fd, logic ib);
        return '{stall: st, bus_req: br, bus_rd: rd, bus_addr: ba, tag_we: tw, tag_val: tv, tag_idx: ti,
                 data_we: dw, data_widx: wi, unc_valid: uv, fill_done: fd, init_busy: ib};
    endfunction
    function automatic out_t e_st(logic st);
        return o(st, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction
    function automatic out_t e_rd(logic [31:0] ba, logic dw, logic [1:0] wi);
        return o(1, 1, 1, ba, 0, 0, 0, dw, wi, 0, 0, 0);
    endfunction
    function automatic out_t e_unc(logic [31:0] ba, logic ack);
        return o(!ack, 1, 1, ba, 0, 0, 0, 0, 0, ack, 0, 0);
    endfunction
    function automatic out_t e_wr(logic [31:0] ba, logic ack);
        return o(!ack, 1, 0, ba, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction
    function automatic out_t e_init(logic [8:0] idx);
        return o(1, 0, 0, 0, 1, 0, idx, 0, 0, 0, 0, 1);
    endfunction
    function automatic out_t cur();
        return o(STALL, BUS_REQ, BUS_RD, BUS_ADDR, TAG_WE, TAG_VAL, TAG_IDX, DATA_WE, DATA_WIDX,
                 UNC_VALID, FILL_DONE, INIT_BUSY);
    endfunction
    // qualified fields are only meaningful while their enable is expected high
    function automatic out_t msk(out_t a, out_t e);
        out_t r = a;
        if (!e.bus_req) begin
            r.bus_rd   = 1'b0;
            r.bus_addr = '0;
        end
        if (!e.tag_we) r.tag_idx = '0;
        if (!e.data_we) r.data_widx = '0;
        return r;
    endfunction
    task automatic chk(input string nm, input out_t a, input out_t e);
        checks++;
        if (msk(a, e) !== msk(e, e)) begin
            failures++;
            $display("FAIL %s: got %h want %h", nm, msk(a, e), msk(e, e));
        end
    endtask
    task automatic drive(input in_t i);
        REQ = i.req; WR = i.wr; KSEG1 = i.kseg1; ADDR = i.addr; HIT = i.hit; BUS_ACK = i.ack;
    endtask
    task automatic step(input string nm, input in_t i, input out_t e);
        drive(i);
        sb.push_back(e);
        @(negedge CLK);
        chk(nm, cur(), sb.pop_front());
        @(posedge CLK);
        #1;
    endtask
    task automatic add(input in_t i, input out_t e);
        tbl.push_back('{i: i, e: e});
    endtask
    task automatic init_walk();
        for (int i = 0; i < 512; i++)
            step($sformatf("init%0d", i), ii(i[0], 1, 0, 32'h80, 0, 1), e_init(9'(i)));
        step("init_done", ii(0, 0, 0, 0, 0, 0), e_st(0));
    endtask
    initial begin
        RESET = 1'b1;
        drive(ii(0, 0, 0, 0, 0, 0));
        step("reset", ii(0, 0, 0, 0, 0, 0), e_init(0));
        RESET = 1'b0;
        init_walk();
        add(ii(1, 0, 0, 32'h1234, 0, 0), e_st(1));
        for (int b = 0; b < 4; b++) begin
            add(b == 1 ? ii(1, 1, 1, 32'hFFFF_FFF0, 1, 0) : ii(1, 0, 0, 32'h1234, 0, 0),
                e_rd(32'h1230 + 32'(4 * b), 0, 0));
            add(ii(1, 0, 0, 32'h1234, 0, 1), e_rd(32'h1230 + 32'(4 * b), 1, 2'(b)));
        end
        add(ii(1, 0, 0, 32'h1234, 0, 0), o(1, 0, 0, 0, 1, 1, 9'h123, 0, 0, 0, 1, 0));
        add(ii(1, 0, 0, 32'h1234, 1, 0), e_st(0));
        add(ii(1, 0, 0, 32'h5678, 1, 0), e_st(0));
        add(ii(1, 0, 0, 32'h9ABC, 1, 1), e_st(0));
        add(ii(1, 0, 1, 32'hA000_0006, 1, 0), e_st(1));
        add(ii(1, 0, 1, 32'hA000_0006, 1, 0), e_unc(32'hA000_0004, 0));
        add(ii(1, 0, 1, 32'hA000_0006, 1, 0), e_unc(32'hA000_0004, 0));
        add(ii(1, 0, 1, 32'hA000_0006, 1, 1), e_unc(32'hA000_0004, 1));
        for (int h = 1; h >= 0; h--) begin
            add(ii(1, 1, 0, 32'h40, h[0], 0), e_st(1));
            add(ii(1, 1, 0, 32'h40, h[0], 0), e_wr(32'h40, 0));
            add(ii(1, 1, 0, 32'h40, h[0], 0), e_wr(32'h40, 0));
            add(ii(1, 1, 0, 32'h40, h[0], 1), e_wr(32'h40, 1));
        end
        add(ii(1, 1, 1, 32'hA000_000B, 0, 0), e_st(1));
        add(ii(1, 1, 1, 32'hA000_000B, 0, 1), e_wr(32'hA000_0008, 1));
        add(ii(0, 0, 0, 0, 0, 1), e_st(0));
        add(ii(0, 0, 0, 0, 0, 0), e_st(0));
        for (int n = 0; n < tbl.size(); n++)
            step($sformatf("vec%0d", n), tbl[n].i, tbl[n].e);
        step("miss2", ii(1, 0, 0, 32'h2000, 0, 0), e_st(1));
        step("r2_ack0", ii(1, 0, 0, 32'h2000, 0, 1), e_rd(32'h2000, 1, 0));
        step("r2_ack1", ii(1, 0, 0, 32'h2000, 0, 1), e_rd(32'h2004, 1, 1));
        drive(ii(1, 0, 0, 32'h2000, 0, 0));
        #1;
        chk("pre_reset", cur(), e_rd(32'h2008, 0, 0));
        RESET = 1'b1;
        #1;
        chk("reset_async", cur(), e_init(0));
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        init_walk();
        step("post_miss", ii(1, 0, 0, 32'h3000, 0, 0), e_st(1));
        step("post_beat0", ii(1, 0, 0, 32'h3000, 0, 1), e_rd(32'h3000, 1, 0));
        step("post_beat1", ii(1, 0, 0, 32'h3000, 0, 0), e_rd(32'h3004, 0, 0));
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d want 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/lmi_dcache_ctrl.md
Name: lmi_dcache_ctrl

Overview:
Sequencer for the data cache tag/data arrays. It performs the post-reset tag invalidation walk and classifies each load/store using the tag-compare hit result. It runs line refills on cached read misses, single-word uncached reads for KSEG1, and write-through bus writes. It drives the pipeline stall and owns the cache side of the LMI bus handshake.

Parameters:
LINE_WORDS, 4, words per cache line; power of 2, minimum 2
WIDX_BITS, 2, log2(LINE_WORDS)
INDEX_BITS, 9, cache line index width; the init walk covers 2^INDEX_BITS lines

Ports:
CLK  in  1  system clock, rising edge
RESET  in  1  asynchronous, active-high reset
REQ  in  1  pipeline memory request valid; held by the pipeline while STALL=1
WR  in  1  1=store, 0=load; qualified by REQ
KSEG1  in  1  uncached address segment; qualified by REQ
ADDR  in  32  byte address of the request
HIT  in  1  tag compare result for ADDR (EN & tag match & valid)
STALL  out  1  pipeline stall
BUS_REQ  out  1  bus transaction request
BUS_RD  out  1  1=read, 0=write; valid while BUS_REQ=1
BUS_ADDR  out  32  word-aligned bus address
BUS_ACK  in  1  one pulse per completed word beat
TAG_WE  out  1  tag RAM write enable
TAG_VAL  out  1  valid bit written with the tag
TAG_IDX  out  INDEX_BITS  tag RAM index during the init walk; during TAGWR it equals ADDR_R[INDEX_BITS+WIDX_BITS+1 : WIDX_BITS+2]
DATA_WE  out  1  data RAM write enable for refill beats
DATA_WIDX  out  WIDX_BITS  word-in-line index for DATA_WE
UNC_VALID  out  1  one-cycle pulse: uncached read data is on the bus
FILL_DONE  out  1  one-cycle pulse: refill complete, tag written
INIT_BUSY  out  1  high during the invalidation walk

Behaviour:
- States: INIT, IDLE, REFILL, TAGWR, UNCRD, WRITE. Encoding is free; next state is registered.
- Reset (asynchronous, any state): state=INIT, init counter=0, beat counter=0, ADDR_R=0.
  - Outputs during reset: STALL=1, INIT_BUSY=1, TAG_WE=1, TAG_VAL=0.
  - All other outputs 0.
  - Reset asserted mid-refill or mid-write aborts the transaction; BUS_REQ drops in the same cycle, asynchronously.
- INIT:
  - TAG_WE=1, TAG_VAL=0, TAG_IDX=counter; counter +1 each cycle.
  - After writing index 2^INDEX_BITS-1, go to IDLE. The walk takes exactly 2^INDEX_BITS cycles.
  - STALL=1 throughout; REQ is ignored.
- IDLE:
  - STALL = REQ & (WR | KSEG1 | ~HIT), combinational in the same cycle.
  - REQ & ~WR & ~KSEG1 & HIT: cached hit, no state change, no bus activity.
  - REQ & ~WR & ~KSEG1 & ~HIT: capture ADDR into ADDR_R, beat counter=0, go to REFILL.
  - REQ & ~WR & KSEG1: capture ADDR, go to UNCRD. HIT is ignored; no cache fill.
  - REQ & WR: capture ADDR, go to WRITE. Write-through and no-allocate regardless of HIT; KSEG1 stores are treated the same way.
- REFILL:
  - BUS_REQ=1, BUS_RD=1.
  - BUS_ADDR = {ADDR_R[31:WIDX_BITS+2], beat, 2'b00}; line-aligned, ascending order, no critical-word-first.
  - DATA_WE = BUS_ACK, with DATA_WIDX = beat in the same cycle. beat increments on each BUS_ACK.
  - The ACK with beat = LINE_WORDS-1 moves to TAGWR; BUS_REQ=0 from the next cycle.
- TAGWR (one cycle):
  - TAG_WE=1, TAG_VAL=1, TAG_IDX from ADDR_R, FILL_DONE=1, STALL=1.
  - Go to IDLE. The replayed REQ then hits.
- UNCRD:
  - BUS_REQ=1, BUS_RD=1, BUS_ADDR = {ADDR_R[31:2], 2'b00}.
  - On BUS_ACK: UNC_VALID=1 and STALL=0 in that cycle, go to IDLE. The pipeline retires the load and must not replay it.
- WRITE:
  - BUS_REQ=1, BUS_RD=0, BUS_ADDR = {ADDR_R[31:2], 2'b00}.
  - On BUS_ACK: STALL=0 in that cycle, go to IDLE.
  - The pipeline updates the data array on a write hit itself; this block does not drive DATA_WE for stores.
- STALL=1 in every non-IDLE state, except the ACK cycle of UNCRD and WRITE.
- BUS_ACK outside REFILL, UNCRD and WRITE is ignored.
- REQ changes while in a non-IDLE state are ignored; ADDR_R is frozen.
- Beat counter wraps modulo LINE_WORDS and is cleared on entry to REFILL.
- Throughput: an uncached read or a write with ACK in cycle k allows a new request to be evaluated in IDLE at cycle k+1.

Test Plan:
- Reset release with INDEX_BITS=9 -> TAG_WE=1/TAG_VAL=0 for 512 cycles, TAG_IDX 0..511, INIT_BUSY falls in cycle 512, then state IDLE.
- Load ADDR=0x0000_1234, HIT=0, BUS_ACK every 2nd cycle -> BUS_ADDR 0x1230, 0x1234, 0x1238, 0x123C; DATA_WIDX 0..3 on ACKs; one TAGWR cycle with TAG_VAL=1 and FILL_DONE; STALL released once HIT=1.
- Load with KSEG1=1, ADDR=0xA000_0006, ACK after 3 cycles -> BUS_ADDR 0xA000_0004, BUS_RD=1; UNC_VALID pulse with the ACK; no TAG_WE or DATA_WE.
- Store ADDR=0x0000_0040 with HIT=1 -> BUS_RD=0, BUS_ADDR 0x40, STALL high until the ACK cycle, no tag write; same again with HIT=0 -> identical response.
- Cached load HIT=1 in IDLE -> STALL=0, BUS_REQ=0 on consecutive cycles.
- RESET asserted after the 2nd refill ACK -> BUS_REQ=0 immediately, full 512-cycle init walk, the first post-init miss starts again at beat 0.
